// File: rtl/z_event_counter.sv
// Comparator output monitor: synchronises z, then counts rising edges and high
// cycles over a programmable window and offers the result on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start; last counts still visible
// RUN    | sampling z_s, remain cycles left in the window
// DONE   | result valid, held until valid && ready
module z_event_counter #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             z,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   output logic             busy,
   output logic             valid,
   input  logic             ready,
   output logic [CNT_W-1:0] edge_cnt,
   output logic [WIN_W-1:0] high_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] EDGE_MAX = '1;

   state_t           state_q, state_d;
   logic             z_m, z_s, z_d;
   logic             z_rise;
   logic [WIN_W-1:0] remain_q, remain_d;
   logic [WIN_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] edge_q, edge_d;

   // Synchroniser and history flop run in every state, so z_d carries
   // pre-window history into the first RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_m <= 1'b0;
         z_s <= 1'b0;
         z_d <= 1'b0;
      end else begin
         z_m <= z;
         z_s <= z_m;
         z_d <= z_s;
      end
   end

   assign z_rise = z_s & ~z_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         remain_q <= '0;
         high_q   <= '0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         high_q   <= high_d;
         edge_q   <= edge_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      high_d   = high_q;
      edge_d   = edge_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               remain_d = win_len;
               high_d   = '0;
               edge_d   = '0;
               state_d  = (win_len != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            high_d   = high_q + {{(WIN_W-1){1'b0}}, z_s};
            if (z_rise && (edge_q != EDGE_MAX))
               edge_d = edge_q + {{(CNT_W-1){1'b0}}, 1'b1};
            remain_d = remain_q - {{(WIN_W-1){1'b0}}, 1'b1};
            if (remain_q == {{(WIN_W-1){1'b0}}, 1'b1})
               state_d = S_DONE;
         end
         S_DONE: begin
            if (ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign valid    = (state_q == S_DONE);
   assign edge_cnt = edge_q;
   assign high_cnt = high_q;

endmodule

// File: doc/z_event_counter.md
# z_event_counter

Downstream monitor for the 4-input comparator output `z`. It synchronises `z` into the system clock domain and counts rising edges and high cycles over a programmable window of clock cycles. It presents the two counts through a valid/ready handshake. It sits directly after the comparator and turns its level output into per-window statistics for the next consumer.

## Interface
Parameters:
- `CNT_W`, 8, width of the rising-edge counter (saturating)
- `WIN_W`, 16, width of the window length and of the high-cycle counter

Ports:
- `clk`  input  1  system clock, rising-edge active
- `rst_n`  input  1  asynchronous, active-low reset
- `z`  input  1  comparator output, asynchronous to `clk`
- `start`  input  1  single-cycle request to begin a window; honoured only in IDLE
- `win_len`  input  WIN_W  window length in cycles, latched on accepted `start`
- `busy`  output  1  high in RUN and DONE
- `valid`  output  1  result available (DONE state)
- `ready`  input  1  consumer accepts result when `valid && ready`
- `edge_cnt`  output  CNT_W  rising edges of synchronised `z` in window
- `high_cnt`  output  WIN_W  cycles synchronised `z` was 1 in window

Clock and reset:
- One clock, `clk`.
- Reset is asynchronous and active-low, `rst_n`.

## Operation
Synchronisation and edge detection:
- A 2-flop synchroniser produces `z_s`; a third flop produces `z_d`, the previous `z_s`.
- This pipeline runs in every state, including IDLE.
- An edge is a cycle with `z_s=1` and `z_d=0`.

FSM states IDLE, RUN, DONE:
- IDLE:
  - On `start=1`, latch `win_len` into `remain`, clear both counters.
  - If `win_len != 0`, go to RUN; if `win_len == 0`, go to DONE.
- RUN:
  - Each cycle: `high_cnt += z_s`; `edge_cnt += edge`.
  - `edge_cnt` saturates at 2^CNT_W−1.
  - `high_cnt` cannot overflow, since it is at most `win_len`.
  - `remain` decrements each cycle; the cycle with `remain==1` is the last sampled cycle, then go to DONE.
- DONE:
  - `valid=1`; counts are held stable.
  - On `valid && ready`, go to IDLE.
- Counts keep their last values in IDLE until the next accepted `start` clears them.

Ignored and simultaneous events:
- `start` in RUN or DONE is ignored, not queued.
- `start` in the handshake cycle is ignored, because the state is still DONE.
- `win_len` changes after `start` have no effect on the current window.

Reset:
- Assertion at any time, including mid-RUN or during DONE:
  - state forced to IDLE;
  - synchroniser, `z_d`, `remain` and counters cleared to 0.
- No partial result is presented after reset.

## Timing
- Reset values:
  - `busy=0`, `valid=0`
  - `edge_cnt=0`, `high_cnt=0`
  - all internal flops 0
- `z` to `z_s` latency: 2 cycles.
- Start acceptance: `start` sampled at edge T. RUN occupies cycles T+1 … T+`win_len`, giving exactly `win_len` samples of `z_s`.
- End of window: `valid` rises at edge T+`win_len`+1, i.e. 1 cycle after the last sample.
- Zero-length window: `win_len=0` gives `valid` at T+1 with both counts 0.
- `busy` is 1 from T+1 until the handshake.
- Handshake: `valid && ready` sampled at edge H gives `valid=0` and `busy=0` after H.
  - With `ready` held high, DONE lasts exactly 1 cycle.
  - A new `start` is honoured from edge H+1.
- Edge at window start: an edge whose `z_s=1, z_d=0` falls in the first RUN cycle is counted, because `z_d` holds pre-window history.
- Counter update rules:
  - All counter updates are registered, taking effect in the cycle after the sample.
  - Saturation is checked before increment; `edge_cnt` never wraps.

## Test plan
- **Constant high:** `z=1` held ≥3 cycles before `start`, `win_len=10` → `edge_cnt=0`, `high_cnt=10`, `valid` 11 cycles after `start`.
- **Square wave:** `z` toggling with period 4 cycles (2 high, 2 low), settled ≥3 cycles before `start`, `win_len=16` → `edge_cnt=4`, `high_cnt=8`.
- **Saturation:** `z` toggling every cycle (period 2), `win_len=600` → `edge_cnt=255` (saturated), `high_cnt=300`.
- **Zero window and backpressure:**
  - `win_len=0` → `valid` 1 cycle after `start`, counts 0.
  - Hold `ready=0` for 5 cycles → `valid` and counts stable throughout; `start` pulses during DONE are ignored.
  - `ready=1` → IDLE next cycle.
- **Mid-run reset:** `win_len=50`, period-4 `z`, assert `rst_n=0` at cycle 20 of RUN → outputs immediately 0 / IDLE.
  - After release, `start` with `win_len=8` yields `edge_cnt=2`, `high_cnt=4`.
- **Ignored start and latch:** `start` pulsed during RUN, and `win_len` changed mid-run → window length and counts unaffected.
